// File: rtl/ps2_scan_ctrl_if.sv
// Bundles the ps2_keyboard FIFO side, the key-event side and the status
// outputs of ps2_scan_ctrl. The slave view belongs to the controller. The
// master view belongs to whoever plays keyboard FIFO and event consumer.
interface ps2_scan_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             ready;
  logic [7:0]       data;
  logic             overflow;
  logic             nextdata_n;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             held_valid;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_flag;
  logic [3:0]       err_cnt;

  modport slave (
    input  ready, data, overflow, evt_ready,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
           held_valid, held_code, press_cnt, ovf_flag, err_cnt
  );

  modport master (
    output ready, data, overflow, evt_ready,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
           held_valid, held_code, press_cnt, ovf_flag, err_cnt
  );
endinterface

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops scan bytes from the ps2_keyboard FIFO one at a time.
// It folds E0/F0 prefixes into a single key event, drops typematic repeats
// of the held key, and counts presses and error bytes. Events leave through
// a valid/ready port. While an event waits in EMIT, no further bytes are
// popped, so unread bytes stay queued in the keyboard FIFO.
module ps2_scan_ctrl #(
  parameter bit          FILTER_REPEAT = 1'b1,
  parameter logic [19:0] PREFIX_TMO    = 20'd1_000_000,
  parameter int          CNT_W         = 8
) (
  input logic            clk,
  input logic            clrn,
  ps2_scan_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;

  localparam logic [19:0] TMO_LAST = PREFIX_TMO - 20'd1;

  logic [1:0]       state;
  logic [7:0]       byte_r;
  logic             ext_p;
  logic             brk_p;
  logic [19:0]      tmr;
  logic [7:0]       evt_code_r;
  logic             evt_ext_r;
  logic             evt_break_r;
  logic             held_valid_r;
  logic             held_ext_r;
  logic [7:0]       held_code_r;
  logic [CNT_W-1:0] press_cnt_r;
  logic             ovf_r;
  logic [3:0]       err_r;
  logic             held_match;

  // The byte under decode, with its pending E0 state, names the held key.
  assign held_match = held_valid_r && (held_ext_r == ext_p) && (held_code_r == byte_r);

  // Sequencer: fetch, pop, decode, and hold each event until it is accepted.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state        <= IDLE;
      byte_r       <= 8'h00;
      ext_p        <= 1'b0;
      brk_p        <= 1'b0;
      tmr          <= 20'd0;
      evt_code_r   <= 8'h00;
      evt_ext_r    <= 1'b0;
      evt_break_r  <= 1'b0;
      held_valid_r <= 1'b0;
      held_ext_r   <= 1'b0;
      held_code_r  <= 8'h00;
      press_cnt_r  <= '0;
      ovf_r        <= 1'b0;
      err_r        <= 4'd0;
    end else begin
      ovf_r <= ovf_r | bus.overflow;
      case (state)
        IDLE: begin
          if (ext_p || brk_p) begin
            if (tmr == TMO_LAST) begin
              ext_p <= 1'b0;
              brk_p <= 1'b0;
              tmr   <= 20'd0;
            end else begin
              tmr <= tmr + 20'd1;
            end
          end
          if (bus.ready) begin
            byte_r <= bus.data;
            state  <= POP;
          end
        end
        POP: begin
          state <= DECODE;
        end
        DECODE: begin
          tmr   <= 20'd0;
          state <= IDLE;
          if (byte_r == 8'hE0) begin
            ext_p <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_p <= 1'b1;
          end else if ((byte_r == 8'h00) || (byte_r == 8'hFF)) begin
            if (err_r != 4'hF) begin
              err_r <= err_r + 4'd1;
            end
            ext_p <= 1'b0;
            brk_p <= 1'b0;
          end else begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            if (brk_p) begin
              if (held_match) begin
                held_valid_r <= 1'b0;
              end
              evt_code_r  <= byte_r;
              evt_ext_r   <= ext_p;
              evt_break_r <= 1'b1;
              state       <= EMIT;
            end else if (!(FILTER_REPEAT && held_match)) begin
              held_valid_r <= 1'b1;
              held_ext_r   <= ext_p;
              held_code_r  <= byte_r;
              press_cnt_r  <= press_cnt_r + CNT_W'(1);
              evt_code_r   <= byte_r;
              evt_ext_r    <= ext_p;
              evt_break_r  <= 1'b0;
              state        <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.evt_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.nextdata_n = (state != POP);
  assign bus.evt_valid  = (state == EMIT);
  assign bus.evt_code   = evt_code_r;
  assign bus.evt_ext    = evt_ext_r;
  assign bus.evt_break  = evt_break_r;
  assign bus.held_valid = held_valid_r;
  assign bus.held_code  = held_code_r;
  assign bus.press_cnt  = press_cnt_r;
  assign bus.ovf_flag   = ovf_r;
  assign bus.err_cnt    = err_r;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: plays the ps2_keyboard FIFO and the event consumer around
// ps2_scan_ctrl. The bench keeps its own key-event model, which works on whole
// popped bytes, and checks every accepted event and the status outputs
// against it.
module tb_ps2_scan_ctrl;

  localparam int TMO = 200;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int pop_count = 0;

  logic [7:0] fifo[$];
  logic [7:0] pend[$];
  logic [9:0] exp_q[$];

  bit         m_ext;
  bit         m_brk;
  bit         m_hv;
  bit         m_hext;
  logic [7:0] m_hcode;
  logic [7:0] m_press;
  int         m_err;
  bit         m_ovf;
  int         m_last_pop;

  bit         prev_low;
  bit         stalled;
  logic [9:0] stall_val;
  logic [9:0] cur_evt;

  ps2_scan_ctrl_if #(.CNT_W(8)) bus ();

  ps2_scan_ctrl #(
    .FILTER_REPEAT(1'b1),
    .PREFIX_TMO   (20'(TMO)),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used by the model to age a pending prefix
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // The model sees whole bytes in FIFO order. A prefix goes stale after a
  // long pop-free gap.
  task automatic model_byte(input logic [7:0] b);
    bit matched;
    if ((m_ext || m_brk) && (cyc - m_last_pop > TMO + 5)) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'h00 || b == 8'hFF) begin
      if (m_err < 15) m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      matched = m_hv && (m_hext == m_ext) && (m_hcode == b);
      if (m_brk) begin
        if (matched) m_hv = 1'b0;
        exp_q.push_back({b, m_ext, 1'b1});
      end else if (!matched) begin
        m_hv    = 1'b1;
        m_hext  = m_ext;
        m_hcode = b;
        m_press = m_press + 8'd1;
        exp_q.push_back({b, m_ext, 1'b0});
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    m_last_pop = cyc;
  endtask

  task automatic model_reset();
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    m_hv    = 1'b0;
    m_hext  = 1'b0;
    m_hcode = 8'h00;
    m_press = 8'h00;
    m_err   = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  // Keyboard FIFO: honour the pop strobe, then expose the new head byte
  always @(negedge clk) begin
    if (bus.nextdata_n === 1'b0) begin
      checkOutput("pop_single", 32'(prev_low), 32'd0);
      checkOutput("pop_ready", 32'(fifo.size() != 0), 32'd1);
      if (fifo.size() != 0) begin
        pop_count++;
        model_byte(fifo.pop_front());
      end
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
    while (pend.size() != 0) fifo.push_back(pend.pop_front());
    bus.ready = (fifo.size() != 0);
    bus.data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Consumer side: score accepted events and hold stalled events steady
  always @(negedge clk) begin
    cur_evt = {bus.evt_code, bus.evt_ext, bus.evt_break};
    if (!clrn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("evt_held", 32'(bus.evt_valid), 32'd1);
        checkOutput("evt_stable", 32'(cur_evt), 32'(stall_val));
      end
      stalled = 1'b0;
      if (bus.evt_valid) begin
        checkOutput("emit_no_pop", 32'(bus.nextdata_n), 32'd1);
        if (bus.evt_ready) begin
          checkOutput("evt_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) checkOutput("evt_fields", 32'(cur_evt), 32'(exp_q.pop_front()));
        end else begin
          stalled   = 1'b1;
          stall_val = cur_evt;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    pend.push_back(b);
  endtask

  task automatic wait_quiet(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < 5000) begin
      @(negedge clk);
      n++;
      if (fifo.size() == 0 && pend.size() == 0 && !bus.evt_valid && bus.nextdata_n) quiet++;
      else quiet = 0;
    end
    checkOutput({tag, "_drain"}, 32'(quiet >= 6), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.evt_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_valid_seen"}, 32'(bus.evt_valid), 32'd1);
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_press_cnt"}, 32'(bus.press_cnt), 32'(m_press));
    checkOutput({tag, "_held_valid"}, 32'(bus.held_valid), 32'(m_hv));
    checkOutput({tag, "_held_code"}, 32'(bus.held_code), 32'(m_hcode));
    checkOutput({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(m_err));
    checkOutput({tag, "_ovf_flag"}, 32'(bus.ovf_flag), 32'(m_ovf));
    checkOutput({tag, "_events_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    checkOutput({tag, "_nextdata_n"}, 32'(bus.nextdata_n), 32'd1);
    checkOutput({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'd0);
    checkOutput({tag, "_evt_code"}, 32'(bus.evt_code), 32'd0);
    checkOutput({tag, "_evt_ext"}, 32'(bus.evt_ext), 32'd0);
    checkOutput({tag, "_evt_break"}, 32'(bus.evt_break), 32'd0);
    checkOutput({tag, "_held_valid"}, 32'(bus.held_valid), 32'd0);
    checkOutput({tag, "_held_code"}, 32'(bus.held_code), 32'd0);
    checkOutput({tag, "_press_cnt"}, 32'(bus.press_cnt), 32'd0);
    checkOutput({tag, "_ovf_flag"}, 32'(bus.ovf_flag), 32'd0);
    checkOutput({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
  endtask

  // Directed scenarios first, then a randomized byte stream
  initial begin
    int p0;
    logic [7:0] b;
    model_reset();
    m_last_pop    = 0;
    bus.evt_ready = 1'b1;
    bus.overflow  = 1'b0;
    clrn          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    clrn = 1'b1;

    p0 = pop_count;
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    wait_quiet("t1");
    check_model("t1");
    checkOutput("t1_pops", 32'(pop_count - p0), 32'd3);
    checkOutput("t1_press_const", 32'(bus.press_cnt), 32'd1);

    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    wait_quiet("t2");
    check_model("t2");
    checkOutput("t2_press_const", 32'(bus.press_cnt), 32'd2);

    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    wait_quiet("t3a");
    check_model("t3a");
    checkOutput("t3_held_code_const", 32'(bus.held_code), 32'h75);
    checkOutput("t3_held_valid_const", 32'(bus.held_valid), 32'd1);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    wait_quiet("t3b");
    check_model("t3b");

    applyStimulus(8'h1C);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("lat_early", 32'(bus.evt_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_3cyc", 32'(bus.evt_valid), 32'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    wait_quiet("lat");

    bus.evt_ready = 1'b0;
    applyStimulus(8'h32);
    applyStimulus(8'hF0);
    applyStimulus(8'h32);
    wait_valid("t4");
    p0 = pop_count;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("t4_no_pop", 32'(pop_count), 32'(p0));
    checkOutput("t4_fifo_hold", 32'(fifo.size()), 32'd2);
    checkOutput("t4_still_valid", 32'(bus.evt_valid), 32'd1);
    bus.evt_ready = 1'b1;
    wait_quiet("t4");
    check_model("t4");

    applyStimulus(8'hF0);
    repeat (2 * TMO) @(posedge clk);
    applyStimulus(8'h1C);
    wait_quiet("t5a");
    check_model("t5a");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    wait_quiet("t5b");
    checkOutput("t5_err_const", 32'(bus.err_cnt), 32'd2);
    for (int i = 0; i < 15; i++) applyStimulus(8'hFF);
    wait_quiet("t5c");
    checkOutput("t5_err_sat", 32'(bus.err_cnt), 32'd15);
    check_model("t5c");

    @(posedge clk);
    #1;
    bus.overflow = 1'b1;
    @(posedge clk);
    #1;
    bus.overflow = 1'b0;
    m_ovf = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_ovf_sticky", 32'(bus.ovf_flag), 32'd1);
    bus.evt_ready = 1'b0;
    applyStimulus(8'h4B);
    wait_valid("t6");
    clrn = 1'b0;
    @(posedge clk);
    #1;
    check_reset("t6_rst");
    model_reset();
    clrn = 1'b1;
    bus.evt_ready = 1'b1;
    wait_quiet("t6");
    check_model("t6");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'h1C;
        2:       b = 8'h32;
        3:       b = 8'h75;
        4, 5:    b = 8'hE0;
        6, 7:    b = 8'hF0;
        8:       b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(b);
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      for (int g = $urandom_range(0, 5); g > 0; g--) begin
        @(posedge clk);
        #1;
        bus.evt_ready = ($urandom_range(0, 3) != 0);
      end
    end
    bus.evt_ready = 1'b1;
    wait_quiet("rand");
    check_model("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
